// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_resp_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Bit counter value reached once a full byte has been clocked
  localparam logic [3:0] BYTE_END = 4'd8;

endpackage

// File: rtl/i2c_target_responder_if.sv
// Bus-side and client-side signals of the I2C target responder, grouped for benches and wrappers.
interface i2c_target_responder_if;
  logic       scl;
  logic       sda;
  logic       sda_pull;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       start;
  logic       stop;
  logic       busy;

  modport slave  (input  scl, sda, rd_data,
                  output sda_pull, wr_data, wr_valid, rd_req, start, stop, busy);
  modport master (output scl, sda, rd_data,
                  input  sda_pull, wr_data, wr_valid, rd_req, start, stop, busy);
endinterface

// File: rtl/i2c_resp_sync.sv
// Synchronizes SCL/SDA into clk_i and derives SCL edges plus START/STOP conditions.
module i2c_resp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_q;
  logic                   r_sda_q;
  logic                   w_scl;
  logic                   w_sda;

  // Flops reset to 1 so the idle bus produces no edges coming out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_q    <= w_scl;
      r_sda_q    <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  assign sda_o      = w_sda;
  assign scl_rise_o =  w_scl & ~r_scl_q;
  assign scl_fall_o = ~w_scl &  r_scl_q;
  // SCL must be steady high across the SDA transition, so a condition never shares a cycle with an SCL edge
  assign start_o    = w_scl & r_scl_q &  r_sda_q & ~w_sda;
  assign stop_o     = w_scl & r_scl_q & ~r_sda_q &  w_sda;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: acknowledges TARGET_ADDR, hands written bytes to the client and serves read bytes from it.
module i2c_target_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_pull_o,
  output logic [7:0] wr_data_o,
  output logic       wr_valid_o,
  output logic       rd_req_o,
  input  logic [7:0] rd_data_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  logic w_sda, w_rise, w_fall, w_start, w_stop;

  i2c_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (w_sda),
    .scl_rise_o (w_rise),
    .scl_fall_o (w_fall),
    .start_o    (w_start),
    .stop_o     (w_stop)
  );

  state_e     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_rd_shift, w_rd_shift_nxt;
  logic [7:0] r_wr_data, w_wr_data_nxt;
  logic       r_pull, w_pull_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_wr_valid, w_wr_valid_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_rd_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rd_shift <= '0;
      r_wr_data  <= '0;
      r_pull     <= 1'b0;
      r_rw       <= 1'b0;
      r_wr_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rd_shift <= w_rd_shift_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_pull     <= w_pull_nxt;
      r_rw       <= w_rw_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_rd_shift_nxt = r_rd_shift;
    w_wr_data_nxt  = r_wr_data;
    w_pull_nxt     = r_pull;
    w_rw_nxt       = r_rw;
    w_wr_valid_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_rd_req       = 1'b0;

    if (w_stop) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_pull_nxt  = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = ADDR;
      w_cnt_nxt   = '0;
      w_pull_nxt  = 1'b0;
      w_busy_nxt  = 1'b1;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_rise && r_cnt != BYTE_END) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
          end else if (w_fall && r_cnt == BYTE_END) begin
            w_cnt_nxt = '0;
            if (r_shift[7:1] == TARGET_ADDR) begin
              w_state_nxt = ADDR_ACK;
              w_pull_nxt  = 1'b1;
              w_rw_nxt    = r_shift[0];
            end else begin
              w_state_nxt = IGNORE;
              w_pull_nxt  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (w_fall) begin
            if (r_rw) begin
              w_state_nxt    = RD_DATA;
              w_rd_req       = 1'b1;
              w_rd_shift_nxt = rd_data_i;
              w_pull_nxt     = ~rd_data_i[7];
            end else begin
              w_state_nxt = WR_DATA;
              w_pull_nxt  = 1'b0;
            end
          end
        end
        WR_DATA: begin
          if (w_rise && r_cnt != BYTE_END) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == BYTE_END - 4'd1) begin
              w_wr_data_nxt  = {r_shift[6:0], w_sda};
              w_wr_valid_nxt = 1'b1;
            end
          end else if (w_fall && r_cnt == BYTE_END) begin
            w_state_nxt = WR_ACK;
            w_pull_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end
        end
        WR_ACK: begin
          if (w_fall) begin
            w_state_nxt = WR_DATA;
            w_pull_nxt  = 1'b0;
          end
        end
        RD_DATA: begin
          // Master samples on the rise; the next bit goes out on the following fall
          if (w_rise && r_cnt != BYTE_END) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_fall) begin
            if (r_cnt == BYTE_END) begin
              w_state_nxt = RD_ACK;
              w_pull_nxt  = 1'b0;
              w_cnt_nxt   = '0;
            end else begin
              w_rd_shift_nxt = {r_rd_shift[6:0], 1'b0};
              w_pull_nxt     = ~r_rd_shift[6];
            end
          end
        end
        RD_ACK: begin
          if (w_rise && w_sda == NACK) begin
            w_state_nxt = IGNORE;
          end else if (w_fall) begin
            w_state_nxt    = RD_DATA;
            w_rd_req       = 1'b1;
            w_rd_shift_nxt = rd_data_i;
            w_pull_nxt     = ~rd_data_i[7];
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_pull_o = r_pull;
  assign wr_data_o  = r_wr_data;
  assign wr_valid_o = r_wr_valid;
  assign rd_req_o   = w_rd_req;
  assign start_o    = w_start;
  assign stop_o     = w_stop;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Randomized bench: a bit-level I2C master drives the responder, a transaction-level target model predicts the bus.
`timescale 1ns/1ps
module tb_i2c_target_responder;
  import i2c_resp_pkg::*;

  localparam logic [6:0] TADDR = 7'h22;
  localparam int Q = 200;

  logic clk, rst_n, m_scl, m_sda;
  logic [7:0] rd_bytes [0:15];
  int rd_idx = 0;
  int nchk = 0, nerr = 0;
  int cnt_start = 0, cnt_stop = 0, cnt_wrv = 0, cnt_rdreq = 0, cnt_pull = 0;
  logic [7:0] wr_log [0:15];

  i2c_target_responder_if bus();

  assign bus.scl     = m_scl;
  assign bus.sda     = m_sda & ~bus.sda_pull;
  assign bus.rd_data = rd_bytes[rd_idx[3:0]];

  i2c_target_responder #(.TARGET_ADDR(TADDR), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scl_i(bus.scl), .sda_i(bus.sda),
    .sda_pull_o(bus.sda_pull), .wr_data_o(bus.wr_data), .wr_valid_o(bus.wr_valid),
    .rd_req_o(bus.rd_req), .rd_data_i(bus.rd_data), .start_o(bus.start),
    .stop_o(bus.stop), .busy_o(bus.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rd_req) rd_idx <= rd_idx + 1;

  always @(negedge clk) begin
    if (bus.start)    cnt_start <= cnt_start + 1;
    if (bus.stop)     cnt_stop  <= cnt_stop + 1;
    if (bus.rd_req)   cnt_rdreq <= cnt_rdreq + 1;
    if (bus.sda_pull) cnt_pull  <= cnt_pull + 1;
    if (bus.wr_valid) begin
      wr_log[cnt_wrv[3:0]] <= bus.wr_data;
      cnt_wrv <= cnt_wrv + 1;
    end
  end

  // Target model: acknowledges exactly its own address
  function automatic logic model_ack(input logic [7:0] addr_byte);
    return (addr_byte[7:1] == TADDR) ? ACK : NACK;
  endfunction

  task automatic bus_start();
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = bus.sda; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(mack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    repeat (5) @(negedge clk);
    nchk++; if (bus.sda_pull !== 1'b0) begin nerr++; $display("FAIL reset_pull got=%b want=0", bus.sda_pull); end
    nchk++; if (bus.wr_valid !== 1'b0 || bus.rd_req !== 1'b0) begin nerr++; $display("FAIL reset_pulses got=%b%b want=00", bus.wr_valid, bus.rd_req); end
    nchk++; if (bus.start !== 1'b0 || bus.stop !== 1'b0 || bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_status got=%b%b%b want=000", bus.start, bus.stop, bus.busy); end
    nchk++; if (bus.wr_data !== 8'h00) begin nerr++; $display("FAIL reset_wr_data got=%h want=00", bus.wr_data); end
    @(negedge clk) rst_n = 1'b1;
    #Q;
  endtask

  task automatic test_write();
    logic [7:0] d [4];
    logic ack;
    int n, s0, p0, w0;
    for (int it = 0; it < 3; it++) begin
      n = (it == 0) ? 1 : int'($urandom_range(2, 4));
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      if (it == 0) d[0] = 8'h5A;
      s0 = cnt_start; p0 = cnt_stop; w0 = cnt_wrv;
      bus_start();
      send_byte({TADDR, 1'b0}, ack);
      nchk++; if (ack !== model_ack({TADDR, 1'b0})) begin nerr++; $display("FAIL wr_addr_ack it=%0d got=%b want=%b", it, ack, model_ack({TADDR, 1'b0})); end
      nchk++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL wr_busy got=%b want=1", bus.busy); end
      for (int k = 0; k < n; k++) begin
        send_byte(d[k], ack);
        nchk++; if (ack !== ACK) begin nerr++; $display("FAIL wr_data_ack it=%0d byte=%0d got=%b want=0", it, k, ack); end
      end
      bus_stop();
      #Q;
      nchk++; if (cnt_wrv - w0 !== n) begin nerr++; $display("FAIL wr_valid_count got=%0d want=%0d", cnt_wrv - w0, n); end
      for (int k = 0; k < n; k++) begin
        nchk++; if (wr_log[(w0 + k) % 16] !== d[k]) begin nerr++; $display("FAIL wr_byte %0d got=%h want=%h", k, wr_log[(w0 + k) % 16], d[k]); end
      end
      nchk++; if (cnt_start - s0 !== 1 || cnt_stop - p0 !== 1) begin nerr++; $display("FAIL wr_start_stop got=%0d/%0d want=1/1", cnt_start - s0, cnt_stop - p0); end
      nchk++; if (bus.busy !== 1'b0 || bus.sda_pull !== 1'b0) begin nerr++; $display("FAIL wr_idle got=%b%b want=00", bus.busy, bus.sda_pull); end
    end
  endtask

  task automatic test_wrong_addr();
    logic [6:0] a;
    logic ack;
    int p0, w0;
    for (int it = 0; it < 2; it++) begin
      a = 7'h23;
      if (it == 1) begin
        a = 7'($urandom);
        while (a == TADDR) a = 7'($urandom);
      end
      p0 = cnt_pull; w0 = cnt_wrv;
      bus_start();
      send_byte({a, 1'b0}, ack);
      nchk++; if (ack !== model_ack({a, 1'b0})) begin nerr++; $display("FAIL nack_addr a=%h got=%b want=%b", a, ack, model_ack({a, 1'b0})); end
      send_byte(8'($urandom), ack);
      nchk++; if (ack !== NACK) begin nerr++; $display("FAIL nack_data a=%h got=%b want=1", a, ack); end
      nchk++; if (dut.r_state !== IGNORE || bus.busy !== 1'b1) begin nerr++; $display("FAIL nack_state got=%0d busy=%b want=%0d busy=1", dut.r_state, bus.busy, IGNORE); end
      bus_stop();
      #Q;
      nchk++; if (cnt_pull - p0 !== 0 || cnt_wrv - w0 !== 0) begin nerr++; $display("FAIL nack_quiet pull=%0d wrv=%0d want=0/0", cnt_pull - p0, cnt_wrv - w0); end
    end
  endtask

  task automatic test_read();
    logic [7:0] exp [4];
    logic [7:0] got;
    logic ack, b;
    int n, r0;
    for (int it = 0; it < 2; it++) begin
      n = (it == 0) ? 2 : int'($urandom_range(1, 4));
      for (int k = 0; k < 4; k++) exp[k] = 8'($urandom);
      if (it == 0) begin exp[0] = 8'hA5; exp[1] = 8'h3C; end
      for (int k = 0; k < 4; k++) rd_bytes[(rd_idx + k) % 16] = exp[k];
      r0 = cnt_rdreq;
      bus_start();
      send_byte({TADDR, 1'b1}, ack);
      nchk++; if (ack !== model_ack({TADDR, 1'b1})) begin nerr++; $display("FAIL rd_addr_ack got=%b want=0", ack); end
      for (int k = 0; k < n; k++) begin
        recv_byte(got, (k == n - 1) ? NACK : ACK);
        nchk++; if (got !== exp[k]) begin nerr++; $display("FAIL rd_byte it=%0d k=%0d got=%h want=%h", it, k, got, exp[k]); end
      end
      nchk++; if (bus.sda_pull !== 1'b0) begin nerr++; $display("FAIL rd_release got=%b want=0", bus.sda_pull); end
      recv_bit(b);
      nchk++; if (b !== 1'b1) begin nerr++; $display("FAIL rd_after_nack got=%b want=1", b); end
      bus_stop();
      #Q;
      nchk++; if (cnt_rdreq - r0 !== n) begin nerr++; $display("FAIL rd_req_count got=%0d want=%0d", cnt_rdreq - r0, n); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [2];
    logic [7:0] got;
    logic ack;
    int s0, w0;
    for (int k = 0; k < 2; k++) exp[k] = 8'($urandom);
    for (int k = 0; k < 2; k++) rd_bytes[(rd_idx + k) % 16] = exp[k];
    s0 = cnt_start; w0 = cnt_wrv;
    bus_start();
    send_byte({TADDR, 1'b0}, ack);
    send_byte(8'h11, ack);
    nchk++; if (ack !== ACK) begin nerr++; $display("FAIL rs_wr_ack got=%b want=0", ack); end
    bus_start();
    nchk++; if (cnt_start - s0 !== 2 || dut.r_state !== ADDR) begin nerr++; $display("FAIL rs_restart starts=%0d state=%0d want=2/%0d", cnt_start - s0, dut.r_state, ADDR); end
    nchk++; if (cnt_wrv - w0 !== 1 || wr_log[w0 % 16] !== 8'h11) begin nerr++; $display("FAIL rs_wr_byte n=%0d got=%h want=1/11", cnt_wrv - w0, wr_log[w0 % 16]); end
    send_byte({TADDR, 1'b1}, ack);
    nchk++; if (ack !== ACK) begin nerr++; $display("FAIL rs_rd_addr got=%b want=0", ack); end
    for (int k = 0; k < 2; k++) begin
      recv_byte(got, (k == 1) ? NACK : ACK);
      nchk++; if (got !== exp[k]) begin nerr++; $display("FAIL rs_rd_byte k=%0d got=%h want=%h", k, got, exp[k]); end
    end
    bus_stop();
    #Q;
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    logic ack, b;
    int p0, r0, w0, s0;
    rd_bytes[rd_idx % 16] = 8'h00;
    bus_start();
    send_byte({TADDR, 1'b1}, ack);
    for (int k = 0; k < 3; k++) begin
      recv_bit(b);
      nchk++; if (b !== 1'b0) begin nerr++; $display("FAIL mr_bit %0d got=%b want=0", k, b); end
    end
    m_sda = 1'b1; #Q; m_scl = 1'b1; #(Q/2);
    nchk++; if (bus.sda_pull !== 1'b1) begin nerr++; $display("FAIL mr_pre_pull got=%b want=1", bus.sda_pull); end
    rst_n = 1'b0;
    #1;
    nchk++; if (bus.sda_pull !== 1'b0) begin nerr++; $display("FAIL mr_async_release got=%b want=0", bus.sda_pull); end
    #(Q/2 - 1); m_scl = 1'b0; #Q;
    @(negedge clk) rst_n = 1'b1;
    #Q;
    p0 = cnt_pull; r0 = cnt_rdreq; w0 = cnt_wrv; s0 = cnt_start;
    d = 8'($urandom);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    nchk++; if (b !== 1'b1 || cnt_pull - p0 !== 0) begin nerr++; $display("FAIL mr_ignored ack=%b pulls=%0d want=1/0", b, cnt_pull - p0); end
    nchk++; if (cnt_rdreq - r0 !== 0 || cnt_wrv - w0 !== 0 || cnt_start - s0 !== 0 || bus.busy !== 1'b0) begin nerr++; $display("FAIL mr_quiet rd=%0d wr=%0d st=%0d busy=%b want=0/0/0/0", cnt_rdreq - r0, cnt_wrv - w0, cnt_start - s0, bus.busy); end
    bus_stop();
    d = 8'($urandom);
    w0 = cnt_wrv;
    bus_start();
    send_byte({TADDR, 1'b0}, ack);
    send_byte(d, b);
    bus_stop();
    #Q;
    nchk++; if (ack !== ACK || b !== ACK || wr_log[w0 % 16] !== d) begin nerr++; $display("FAIL mr_fresh ack=%b%b byte=%h want=00 %h", ack, b, wr_log[w0 % 16], d); end
  endtask

  task automatic test_stop_mid_byte();
    logic ack;
    int w0;
    w0 = cnt_wrv;
    bus_start();
    send_byte({TADDR, 1'b0}, ack);
    nchk++; if (ack !== ACK) begin nerr++; $display("FAIL sm_addr_ack got=%b want=0", ack); end
    for (int k = 0; k < 3; k++) send_bit(1'($urandom));
    bus_stop();
    #Q;
    nchk++; if (cnt_wrv - w0 !== 0) begin nerr++; $display("FAIL sm_no_wr got=%0d want=0", cnt_wrv - w0); end
    nchk++; if (dut.r_state !== IDLE || bus.sda_pull !== 1'b0 || bus.busy !== 1'b0) begin nerr++; $display("FAIL sm_idle state=%0d pull=%b busy=%b want=%0d/0/0", dut.r_state, bus.sda_pull, bus.busy, IDLE); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) rd_bytes[k] = 8'h00;
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_back_to_back();
    test_reset_mid_read();
    test_stop_mid_byte();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/i2c_target_responder.md
I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

Interface
REQ-001 The block SHALL have parameter TARGET_ADDR, default 7'h22, meaning the 7-bit I2C address the block answers to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on scl_i/sda_i (legal values 2..4).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single system clock, at least 8x the SCL rate.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port scl_i, input, 1 bit: bus SCL, asynchronous to clk_i.
REQ-006 The block SHALL have port sda_i, input, 1 bit: bus SDA, asynchronous to clk_i.
REQ-007 The block SHALL have port sda_pull_o, output, 1 bit: 1 = drive SDA low, 0 = release (open-drain).
REQ-008 The block SHALL have port wr_data_o, output, 8 bits: last byte received in a write transfer.
REQ-009 The block SHALL have port wr_valid_o, output, 1 bit: one-cycle pulse; wr_data_o is valid in that cycle.
REQ-010 The block SHALL have port rd_req_o, output, 1 bit: one-cycle pulse requesting the next read byte.
REQ-011 The block SHALL have port rd_data_i, input, 8 bits: read byte, sampled in the rd_req_o cycle.
REQ-012 The block SHALL have port start_o, output, 1 bit: one-cycle pulse per detected START or repeated START.
REQ-013 The block SHALL have port stop_o, output, 1 bit: one-cycle pulse per detected STOP.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high from START to STOP.

Function
REQ-015 scl_i and sda_i SHALL pass through SYNC_STAGES flops; all edge and condition detection SHALL use the synchronized values.
REQ-016 START SHALL be detected as a synced SDA fall while synced SCL is high; STOP as a synced SDA rise while synced SCL is high.
REQ-017 FSM states SHALL be: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-018 START in any state SHALL enter ADDR, clear the bit counter, and release sda_pull_o; STOP in any state SHALL enter IDLE and release sda_pull_o.
REQ-019 Data bits SHALL be sampled MSB first on the SCL rising edge; sda_pull_o SHALL change only on the SCL falling edge.
REQ-020 ADDR: after 8 bits, if bits[7:1] == TARGET_ADDR, the block SHALL assert sda_pull_o on the next SCL fall (ADDR_ACK); otherwise it SHALL enter IGNORE with SDA released.
REQ-021 After ADDR_ACK, the next SCL fall SHALL release SDA and enter WR_DATA if R/W=0; if R/W=1 it SHALL enter RD_DATA and drive bit 7 of the read byte.
REQ-022 rd_req_o SHALL pulse in the cycle of the SCL fall ending ADDR_ACK or RD_ACK (master ACK), and rd_data_i SHALL be captured in that same cycle.
REQ-023 WR_DATA: after the 8th bit, wr_data_o SHALL update and wr_valid_o SHALL pulse within 1 cycle of that SCL rise; the block SHALL ACK (WR_ACK) and return to WR_DATA.
REQ-024 RD_DATA: sda_pull_o SHALL equal the inverse of the current data bit; after 8 bits SDA SHALL be released for RD_ACK.
REQ-025 RD_ACK: on a master ACK (SDA low at SCL rise) the block SHALL continue with the next byte; on a NACK it SHALL enter IGNORE.
REQ-026 IGNORE SHALL keep SDA released and leave only on START or STOP.
REQ-027 The bit counter SHALL be 4 bits and count 0..8, wrapping to 0 at each byte boundary.
REQ-028 A START or STOP coincident with an SCL edge SHALL take priority over the SCL edge.

Reset
REQ-029 While rst_ni is low: FSM = IDLE, counters and shift registers = 0, all outputs = 0, synchronizer flops = 1 (bus idle).
REQ-030 An assertion of rst_ni mid-transfer SHALL release SDA immediately (asynchronously), and after release the block SHALL wait for a fresh START.

Structure
REQ-031 The FSM state enum and ACK/NACK constants SHALL live in shared package i2c_resp_pkg.
REQ-032 Synchronization and edge/START/STOP detection SHALL be the sub-module i2c_resp_sync.

Verification
REQ-033 START, address 0x44 (0x22 write), data 0x5A, STOP -> ACK on both 9th bits, wr_valid_o pulse with 0x5A, start_o and stop_o pulse once each.
REQ-034 START, address 0x46 (0x23) -> SDA never pulled; the FSM stays in IGNORE until STOP; no wr_valid_o.
REQ-035 START, address 0x45 with rd_data_i=0xA5 then 0x3C, master ACK then NACK -> bus reads 0xA5, 0x3C; two rd_req_o pulses; SDA released after the NACK.
REQ-036 Write 0x11, repeated START, read -> second start_o pulse; the FSM re-enters ADDR; the read completes correctly.
REQ-037 rst_ni low during bit 4 of a read -> sda_pull_o goes to 0 at once; the next data bits are ignored until a new START.
REQ-038 STOP after 3 bits of a write byte -> IDLE, no wr_valid_o, SDA released.
